// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with programmable latency,
// byte-strobed writes, out-of-range error flag and saturating access counters.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [33:0] BASE_ADDR  = 34'h0,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [3:0]  mem_wstrb,
    input  logic [33:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    input  logic        stall_req,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
    localparam logic [34:0] SIZE = 35'd4 << DEPTH_LOG2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [33:0]           addr_q;
    logic [3:0]            wstrb_q;
    logic [31:0]           wdata_q;
    logic                  ready_q, err_q;
    logic [31:0]           rdata_q, rd_count_q, wr_count_q;
    logic [31:0]           mem_q [2**DEPTH_LOG2];
    logic                  accept, in_range, is_write, resp;
    logic [34:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           merged;

    // The ready cycle blocks capture so a held mem_valid is not taken twice.
    assign accept   = state_q == S_IDLE && mem_valid && !ready_q;
    assign resp     = state_q == S_RESP;
    // Addresses below BASE_ADDR wrap to a huge offset and fail the bound.
    assign off      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign in_range = off < SIZE;
    assign idx      = DEPTH_LOG2'(off >> 2);
    assign is_write = |wstrb_q;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem_q[idx][8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = LATENCY == 0 ? S_RESP : S_WAIT;
            cnt_d   = 4'(LATENCY);
        end else if (state_q == S_WAIT && !stall_req) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
        end else if (resp) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= resp;
            err_q   <= resp && !in_range;
            if (resp) begin
                rdata_q <= !in_range ? '0 : is_write ? merged : mem_q[idx];
                if (is_write)
                    wr_count_q <= wr_count_q + 32'(wr_count_q != '1);
                else
                    rd_count_q <= rd_count_q + 32'(rd_count_q != '1);
            end
        end
    end

    // Array and captured request carry no reset; a reset in RESP suppresses the write.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_addr;
            wstrb_q <= mem_wstrb;
            wdata_q <= mem_wdata;
        end
        if (resetn && resp && in_range && is_write)
            mem_q[idx] <= merged;
    end

    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
endmodule
